// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, ALU codes, state encoding and class helpers for the control sequencer
package cpu_pkg;

  localparam int ALU_W = 4;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd3;
  localparam logic [3:0] ALU_SHR = 4'd4;
  localparam logic [3:0] ALU_SHL = 4'd5;
  localparam logic [3:0] ALU_ROR = 4'd6;
  localparam logic [3:0] ALU_ROL = 4'd7;
  localparam logic [3:0] ALU_MUL = 4'd8;
  localparam logic [3:0] ALU_DIV = 4'd9;
  localparam logic [3:0] ALU_NEG = 4'd10;
  localparam logic [3:0] ALU_NOT = 4'd11;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_SHL  = 5'd8;
  localparam logic [4:0] OP_ROR  = 5'd9;
  localparam logic [4:0] OP_ROL  = 5'd10;
  localparam logic [4:0] OP_ADDI = 5'd11;
  localparam logic [4:0] OP_ANDI = 5'd12;
  localparam logic [4:0] OP_ORI  = 5'd13;
  localparam logic [4:0] OP_MUL  = 5'd14;
  localparam logic [4:0] OP_DIV  = 5'd15;
  localparam logic [4:0] OP_NEG  = 5'd16;
  localparam logic [4:0] OP_NOT  = 5'd17;
  localparam logic [4:0] OP_BR   = 5'd18;
  localparam logic [4:0] OP_JR   = 5'd19;
  localparam logic [4:0] OP_JAL  = 5'd20;
  localparam logic [4:0] OP_IN   = 5'd21;
  localparam logic [4:0] OP_OUT  = 5'd22;
  localparam logic [4:0] OP_MFHI = 5'd23;
  localparam logic [4:0] OP_MFLO = 5'd24;
  localparam logic [4:0] OP_NOP  = 5'd25;
  localparam logic [4:0] OP_HALT = 5'd26;

  localparam logic [3:0] ST_RESET = 4'd0;
  localparam logic [3:0] ST_T0    = 4'd1;
  localparam logic [3:0] ST_T1    = 4'd2;
  localparam logic [3:0] ST_T2    = 4'd3;
  localparam logic [3:0] ST_T3    = 4'd4;
  localparam logic [3:0] ST_T4    = 4'd5;
  localparam logic [3:0] ST_T5    = 4'd6;
  localparam logic [3:0] ST_T6    = 4'd7;
  localparam logic [3:0] ST_T7    = 4'd8;
  localparam logic [3:0] ST_HALT  = 4'd9;

  localparam int NUM_CLASS = 16;

  typedef enum logic [3:0] {
    CL_LD, CL_LDI, CL_ST, CL_RALU, CL_IALU, CL_MULDIV, CL_NEGNOT, CL_BR,
    CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT
  } iclass_e;

  // Final execute step of each instruction class; the sequencer returns to T0 after it.
  function automatic logic [3:0] last_step(input logic [NUM_CLASS-1:0] cls);
    logic [3:0] s;
    s = ST_T3;
    if (cls[CL_LD] || cls[CL_ST])                           s = ST_T7;
    else if (cls[CL_MULDIV] || cls[CL_BR])                  s = ST_T6;
    else if (cls[CL_LDI] || cls[CL_RALU] || cls[CL_IALU])   s = ST_T5;
    else if (cls[CL_NEGNOT] || cls[CL_JAL])                 s = ST_T4;
    return s;
  endfunction

endpackage

// File: rtl/ir_class_decode.sv
// rtl/ir_class_decode.sv - opcode to one-hot instruction class and ALU operation
module ir_class_decode
  import cpu_pkg::*;
(
  input  logic [4:0]           op,
  output logic [NUM_CLASS-1:0] cls,
  output logic [ALU_W-1:0]     alu
);

  // Pure lookup; nop and every undefined opcode fall into the nop class.
  always_comb begin
    cls = '0;
    alu = ALU_AND;
    case (op)
      OP_LD:   cls[CL_LD]  = 1'b1;
      OP_LDI:  cls[CL_LDI] = 1'b1;
      OP_ST:   cls[CL_ST]  = 1'b1;
      OP_ADD:  begin cls[CL_RALU] = 1'b1; alu = ALU_ADD; end
      OP_SUB:  begin cls[CL_RALU] = 1'b1; alu = ALU_SUB; end
      OP_AND:  begin cls[CL_RALU] = 1'b1; alu = ALU_AND; end
      OP_OR:   begin cls[CL_RALU] = 1'b1; alu = ALU_OR;  end
      OP_SHR:  begin cls[CL_RALU] = 1'b1; alu = ALU_SHR; end
      OP_SHL:  begin cls[CL_RALU] = 1'b1; alu = ALU_SHL; end
      OP_ROR:  begin cls[CL_RALU] = 1'b1; alu = ALU_ROR; end
      OP_ROL:  begin cls[CL_RALU] = 1'b1; alu = ALU_ROL; end
      OP_ADDI: begin cls[CL_IALU] = 1'b1; alu = ALU_ADD; end
      OP_ANDI: begin cls[CL_IALU] = 1'b1; alu = ALU_AND; end
      OP_ORI:  begin cls[CL_IALU] = 1'b1; alu = ALU_OR;  end
      OP_MUL:  begin cls[CL_MULDIV] = 1'b1; alu = ALU_MUL; end
      OP_DIV:  begin cls[CL_MULDIV] = 1'b1; alu = ALU_DIV; end
      OP_NEG:  begin cls[CL_NEGNOT] = 1'b1; alu = ALU_NEG; end
      OP_NOT:  begin cls[CL_NEGNOT] = 1'b1; alu = ALU_NOT; end
      OP_BR:   cls[CL_BR]   = 1'b1;
      OP_JR:   cls[CL_JR]   = 1'b1;
      OP_JAL:  cls[CL_JAL]  = 1'b1;
      OP_IN:   cls[CL_IN]   = 1'b1;
      OP_OUT:  cls[CL_OUT]  = 1'b1;
      OP_MFHI: cls[CL_MFHI] = 1'b1;
      OP_MFLO: cls[CL_MFLO] = 1'b1;
      OP_HALT: cls[CL_HALT] = 1'b1;
      default: cls[CL_NOP]  = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired fetch/decode/execute sequencer driving the datapath strobes
module control_unit
  import cpu_pkg::*;
#(
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [31:0]         ir,
  input  logic                con_out,
  output logic                gra, grb, grc, r_in, r_out, ba_out,
  output logic                pc_in, pc_out, inc_pc, ir_in, mar_in, mdr_in, mdr_out,
  output logic                y_in, z_in, z_low_out, z_high_out,
  output logic                hi_in, hi_out, lo_in, lo_out, c_out, con_in,
  output logic                inport_out, outport_in, read, write,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                run
);

  logic [3:0]           r_state;
  logic [3:0]           w_step;
  logic [3:0]           w_next;
  logic [NUM_CLASS-1:0] w_cls;
  logic [ALU_W-1:0]     w_alu;
  logic                 w_mem;
  logic                 w_unused_ir;

  assign w_unused_ir = ^ir[26:0];
  assign w_mem       = w_cls[CL_LD] | w_cls[CL_LDI] | w_cls[CL_ST];

  ir_class_decode u_dec (
    .op  (ir[31:27]),
    .cls (w_cls),
    .alu (w_alu)
  );

  // ir is loaded on the same edge that leaves T2, so the T2 exit cannot see the new
  // opcode. T3 holding a nop therefore acts as the next T0, and holding a halt acts as HALT.
  always_comb begin
    w_step = r_state;
    if (r_state == ST_T3 && w_cls[CL_NOP])       w_step = ST_T0;
    else if (r_state == ST_T3 && w_cls[CL_HALT]) w_step = ST_HALT;
  end

  // Step advance: fetch is fixed, execute ends at the class's last step, HALT is sticky.
  always_comb begin
    w_next = w_step;
    case (w_step)
      ST_RESET:           w_next = ST_T0;
      ST_T0, ST_T1, ST_T2: w_next = w_step + 4'd1;
      ST_HALT:            w_next = ST_HALT;
      default:            w_next = (w_step >= last_step(w_cls)) ? ST_T0 : w_step + 4'd1;
    endcase
  end

  // State register; reset forces RESET at once, even mid-instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_RESET;
    else          r_state <= w_next;
  end

  // Output decode of the effective step and instruction class; everything idles at zero/And.
  always_comb begin
    {gra, grb, grc, r_in, r_out, ba_out} = '0;
    {pc_in, pc_out, inc_pc, ir_in, mar_in, mdr_in, mdr_out} = '0;
    {y_in, z_in, z_low_out, z_high_out} = '0;
    {hi_in, hi_out, lo_in, lo_out, c_out, con_in} = '0;
    {inport_out, outport_in, read, write} = '0;
    alu_op = ALU_AND;
    run    = (w_step != ST_RESET) && (w_step != ST_HALT);
    case (w_step)
      ST_T0: begin pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1; alu_op = ALU_ADD; end
      ST_T1: begin z_low_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1; end
      ST_T2: begin mdr_out = 1'b1; ir_in = 1'b1; end
      ST_T3: begin
        if (w_mem)                                begin grb = 1'b1; ba_out = 1'b1; y_in = 1'b1; end
        else if (w_cls[CL_RALU] | w_cls[CL_IALU]) begin grb = 1'b1; r_out = 1'b1; y_in = 1'b1; end
        else if (w_cls[CL_MULDIV])                begin gra = 1'b1; r_out = 1'b1; y_in = 1'b1; end
        else if (w_cls[CL_NEGNOT])                begin grb = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = w_alu; end
        else if (w_cls[CL_BR])                    begin gra = 1'b1; r_out = 1'b1; con_in = 1'b1; end
        else if (w_cls[CL_JR])                    begin gra = 1'b1; r_out = 1'b1; pc_in = 1'b1; end
        else if (w_cls[CL_JAL])                   begin pc_out = 1'b1; grb = 1'b1; r_in = 1'b1; end
        else if (w_cls[CL_IN])                    begin inport_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
        else if (w_cls[CL_OUT])                   begin gra = 1'b1; r_out = 1'b1; outport_in = 1'b1; end
        else if (w_cls[CL_MFHI])                  begin hi_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
        else if (w_cls[CL_MFLO])                  begin lo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
      end
      ST_T4: begin
        if (w_mem)                   begin c_out = 1'b1; z_in = 1'b1; alu_op = ALU_ADD; end
        else if (w_cls[CL_RALU])     begin grc = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = w_alu; end
        else if (w_cls[CL_IALU])     begin c_out = 1'b1; z_in = 1'b1; alu_op = w_alu; end
        else if (w_cls[CL_MULDIV])   begin grb = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = w_alu; end
        else if (w_cls[CL_NEGNOT])   begin z_low_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
        else if (w_cls[CL_BR])       begin pc_out = 1'b1; y_in = 1'b1; end
        else if (w_cls[CL_JAL])      begin gra = 1'b1; r_out = 1'b1; pc_in = 1'b1; end
      end
      ST_T5: begin
        if (w_cls[CL_LD] | w_cls[CL_ST]) begin z_low_out = 1'b1; mar_in = 1'b1; end
        else if (w_cls[CL_LDI] | w_cls[CL_RALU] | w_cls[CL_IALU])
                                       begin z_low_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
        else if (w_cls[CL_MULDIV])     begin z_low_out = 1'b1; lo_in = 1'b1; end
        else if (w_cls[CL_BR])         begin c_out = 1'b1; z_in = 1'b1; alu_op = ALU_ADD; end
      end
      ST_T6: begin
        if (w_cls[CL_LD])            begin read = 1'b1; mdr_in = 1'b1; end
        else if (w_cls[CL_ST])       begin gra = 1'b1; r_out = 1'b1; mdr_in = 1'b1; end
        else if (w_cls[CL_MULDIV])   begin z_high_out = 1'b1; hi_in = 1'b1; end
        else if (w_cls[CL_BR])       begin z_low_out = 1'b1; pc_in = con_out; end
      end
      ST_T7: begin
        if (w_cls[CL_LD])            begin mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
        else if (w_cls[CL_ST])       write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit against a microprogram model
module tb_control_unit;

  localparam logic [26:0] WRITE = 27'h1, READ = 27'h2, OUTPORT_IN = 27'h4, INPORT_OUT = 27'h8;
  localparam logic [26:0] CON_IN = 27'h10, C_OUT = 27'h20, LO_OUT = 27'h40, LO_IN = 27'h80;
  localparam logic [26:0] HI_OUT = 27'h100, HI_IN = 27'h200, Z_HIGH_OUT = 27'h400, Z_LOW_OUT = 27'h800;
  localparam logic [26:0] Z_IN = 27'h1000, Y_IN = 27'h2000, MDR_OUT = 27'h4000, MDR_IN = 27'h8000;
  localparam logic [26:0] MAR_IN = 27'h10000, IR_IN = 27'h20000, INC_PC = 27'h40000, PC_OUT = 27'h80000;
  localparam logic [26:0] PC_IN = 27'h100000, BA_OUT = 27'h200000, R_OUT = 27'h400000, R_IN = 27'h800000;
  localparam logic [26:0] GRC = 27'h1000000, GRB = 27'h2000000, GRA = 27'h4000000;

  typedef struct packed { logic [26:0] v; logic [3:0] a; } step_t;

  logic clk, reset_n, con_out;
  logic [31:0] ir;
  logic gra, grb, grc, r_in, r_out, ba_out, pc_in, pc_out, inc_pc, ir_in, mar_in, mdr_in, mdr_out;
  logic y_in, z_in, z_low_out, z_high_out, hi_in, hi_out, lo_in, lo_out, c_out, con_in;
  logic inport_out, outport_in, read, write, run;
  logic [3:0] alu_op;
  logic [26:0] obs;

  int n_tests = 0, n_fail = 0;
  step_t prog[$];
  logic [26:0] exp_vec;
  logic [3:0]  exp_alu;
  logic        exp_run;

  control_unit #(.ALU_OP_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .ir(ir), .con_out(con_out),
    .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out), .ba_out(ba_out),
    .pc_in(pc_in), .pc_out(pc_out), .inc_pc(inc_pc), .ir_in(ir_in), .mar_in(mar_in),
    .mdr_in(mdr_in), .mdr_out(mdr_out), .y_in(y_in), .z_in(z_in), .z_low_out(z_low_out),
    .z_high_out(z_high_out), .hi_in(hi_in), .hi_out(hi_out), .lo_in(lo_in), .lo_out(lo_out),
    .c_out(c_out), .con_in(con_in), .inport_out(inport_out), .outport_in(outport_in),
    .read(read), .write(write), .alu_op(alu_op), .run(run)
  );

  assign obs = {gra, grb, grc, r_in, r_out, ba_out, pc_in, pc_out, inc_pc, ir_in, mar_in, mdr_in,
                mdr_out, y_in, z_in, z_low_out, z_high_out, hi_in, hi_out, lo_in, lo_out, c_out,
                con_in, inport_out, outport_in, read, write};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void push(input logic [26:0] v, input logic [3:0] a);
    prog.push_back('{v: v, a: a});
  endfunction

  function automatic logic [3:0] alu_of(input logic [4:0] op);
    case (op)
      5'd3, 5'd11: return 4'd2;
      5'd4:        return 4'd3;
      5'd6, 5'd13: return 4'd1;
      5'd7:        return 4'd4;
      5'd8:        return 4'd5;
      5'd9:        return 4'd6;
      5'd10:       return 4'd7;
      5'd14:       return 4'd8;
      5'd15:       return 4'd9;
      5'd16:       return 4'd10;
      5'd17:       return 4'd11;
      default:     return 4'd0;
    endcase
  endfunction

  // Microprogram for one instruction, written straight from the step tables.
  function automatic void build_prog(input logic [4:0] op, input logic cond);
    logic [3:0] a;
    a = alu_of(op);
    prog.delete();
    push(PC_OUT | MAR_IN | INC_PC | Z_IN, 4'd2);
    push(Z_LOW_OUT | PC_IN | READ | MDR_IN, 4'd0);
    push(MDR_OUT | IR_IN, 4'd0);
    if (op <= 5'd2) begin
      push(GRB | BA_OUT | Y_IN, 4'd0);
      push(C_OUT | Z_IN, 4'd2);
      if (op == 5'd1) push(Z_LOW_OUT | GRA | R_IN, 4'd0);
      else begin
        push(Z_LOW_OUT | MAR_IN, 4'd0);
        if (op == 5'd0) begin push(READ | MDR_IN, 4'd0); push(MDR_OUT | GRA | R_IN, 4'd0); end
        else begin push(GRA | R_OUT | MDR_IN, 4'd0); push(WRITE, 4'd0); end
      end
    end else if (op <= 5'd13) begin
      push(GRB | R_OUT | Y_IN, 4'd0);
      push(((op <= 5'd10) ? (GRC | R_OUT) : C_OUT) | Z_IN, a);
      push(Z_LOW_OUT | GRA | R_IN, 4'd0);
    end else if (op <= 5'd15) begin
      push(GRA | R_OUT | Y_IN, 4'd0);
      push(GRB | R_OUT | Z_IN, a);
      push(Z_LOW_OUT | LO_IN, 4'd0);
      push(Z_HIGH_OUT | HI_IN, 4'd0);
    end else if (op <= 5'd17) begin
      push(GRB | R_OUT | Z_IN, a);
      push(Z_LOW_OUT | GRA | R_IN, 4'd0);
    end else if (op == 5'd18) begin
      push(GRA | R_OUT | CON_IN, 4'd0);
      push(PC_OUT | Y_IN, 4'd0);
      push(C_OUT | Z_IN, 4'd2);
      push(Z_LOW_OUT | (cond ? PC_IN : 27'h0), 4'd0);
    end else if (op == 5'd19) push(GRA | R_OUT | PC_IN, 4'd0);
    else if (op == 5'd20) begin
      push(PC_OUT | GRB | R_IN, 4'd0);
      push(GRA | R_OUT | PC_IN, 4'd0);
    end
    else if (op == 5'd21) push(INPORT_OUT | GRA | R_IN, 4'd0);
    else if (op == 5'd22) push(GRA | R_OUT | OUTPORT_IN, 4'd0);
    else if (op == 5'd23) push(HI_OUT | GRA | R_IN, 4'd0);
    else if (op == 5'd24) push(LO_OUT | GRA | R_IN, 4'd0);
  endfunction

  // Compare process: DUT outputs against the current model expectation, mid-cycle.
  always @(negedge clk) begin
    int drv;
    drv = int'(r_out) + int'(ba_out) + int'(pc_out) + int'(mdr_out) + int'(z_low_out)
        + int'(z_high_out) + int'(hi_out) + int'(lo_out) + int'(c_out) + int'(inport_out);
    chk("strobes", {5'd0, obs}, {5'd0, exp_vec});
    chk("alu_op", {28'd0, alu_op}, {28'd0, exp_alu});
    chk("run", {31'd0, run}, {31'd0, exp_run});
    chk("bus_drivers_le1", {31'd0, drv <= 1}, 32'd1);
    chk("no_read_and_write", {31'd0, read & write}, 32'd0);
  end

  // Runs up to max_steps steps of one instruction starting in T0; ir loads at the T2 edge.
  task automatic do_instr(input logic [31:0] word, input logic cond, input int max_steps);
    build_prog(word[31:27], cond);
    for (int k = 0; k < prog.size() && k < max_steps; k++) begin
      exp_vec = prog[k].v;
      exp_alu = prog[k].a;
      exp_run = 1'b1;
      con_out = (k == 6) ? cond : ~cond;
      @(posedge clk); #1;
      if (k == 2) ir = word;
    end
  endtask

  task automatic idle_exp();
    exp_vec = '0; exp_alu = 4'd0; exp_run = 1'b0;
  endtask

  logic [31:0] words [30] = '{
    32'h18918000, 32'h20000000, 32'h28000000, 32'h30000000, 32'h38000000, 32'h40000000,
    32'h48000000, 32'h50000000, 32'h58000000, 32'h60000000, 32'h68000000, 32'h71A00000,
    32'h78000000, 32'h80000000, 32'h88000000, 32'h91000035, 32'h91000035, 32'h98000000,
    32'hA0000000, 32'hA8000000, 32'hB0000000, 32'hB8000000, 32'hC0000000, 32'hC8000000,
    32'hD8000000, 32'hF8000000, 32'h00800065, 32'h08800065, 32'h10800065, 32'hD0000000};
  logic conds [30] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0,0,0,0,0,0,0};

  initial begin
    reset_n = 1'b0; ir = 32'h0; con_out = 1'b0;
    idle_exp();

    build_prog(5'd3, 1'b0);  chk("model_len_add", prog.size(), 6);
    build_prog(5'd18, 1'b1); chk("model_len_br", prog.size(), 7);
    build_prog(5'd0, 1'b0);  chk("model_len_ld", prog.size(), 8);
    build_prog(5'd2, 1'b0);  chk("model_len_st", prog.size(), 8);
    build_prog(5'd19, 1'b0); chk("model_len_jr", prog.size(), 4);
    build_prog(5'd25, 1'b0); chk("model_len_nop", prog.size(), 3);
    build_prog(5'd14, 1'b0); chk("model_mul_t5", {5'd0, prog[5].v}, {5'd0, Z_LOW_OUT | LO_IN});

    repeat (2) @(posedge clk);
    #1;
    chk("reset_run", {31'd0, run}, 32'd0);
    chk("reset_strobes", {5'd0, obs}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("first_t0_pc_out", {31'd0, pc_out}, 32'd1);
    chk("first_t0_inc_pc", {31'd0, inc_pc}, 32'd1);
    chk("first_t0_alu_add", {28'd0, alu_op}, 32'd2);

    for (int i = 0; i < 30; i++) do_instr(words[i], conds[i], 100);

    idle_exp();
    repeat (20) @(posedge clk);
    #1;
    chk("halt_run_low", {31'd0, run}, 32'd0);
    chk("halt_no_fetch", {31'd0, pc_out | read}, 32'd0);

    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    do_instr(32'h18918000, 1'b0, 100);
    do_instr(32'h18918000, 1'b0, 4);
    idle_exp();
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_strobes", {5'd0, obs}, 32'd0);
    chk("async_reset_run", {31'd0, run}, 32'd0);
    chk("async_reset_alu", {28'd0, alu_op}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    do_instr(32'h71A00000, 1'b0, 100);
    do_instr(32'h91000035, 1'b1, 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
